// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: access-width codes, FSM states
// and the EX/MEM and MEM/WB pipeline register layouts.
package mem_stage_pkg;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [31:0] pc_plus_4;
    logic [4:0]  rd;
    logic        mem_read;
    logic        mem_write;
    logic        mem_unsigned;
    logic [1:0]  mem_width;
    logic        reg_write;
    logic        mem_to_reg;
    logic        valid;
  } ex_mem_reg_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        valid;
  } mem_wb_reg_t;

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane steering for the data bus: store byte enables and replicated
// write data, plus load extraction with sign/zero extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  input  logic        load_unsigned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (addr_lo)
      2'd0:    byte_sel = load_data[7:0];
      2'd1:    byte_sel = load_data[15:8];
      2'd2:    byte_sel = load_data[23:16];
      default: byte_sel = load_data[31:24];
    endcase
    half_sel = addr_lo[1] ? load_data[31:16] : load_data[15:0];
  end

  // Width code 11 falls into the word arm on purpose.
  always_comb begin
    be       = 4'b1111;
    wdata    = store_data;
    load_ext = load_data;
    case (width)
      MEM_B: begin
        be       = 4'b0001 << addr_lo;
        wdata    = {4{store_data[7:0]}};
        load_ext = {{24{~load_unsigned & byte_sel[7]}}, byte_sel};
      end
      MEM_H: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{store_data[15:0]}};
        load_ext = {{16{~load_unsigned & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives a req/ack data bus from the EX/MEM register and
// builds the next MEM/WB value. Optional macro MEM_MISALIGN_TRAP_EN traps
// misaligned half/word accesses instead of issuing them.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  ex_mem_reg_t       ex_mem_reg,
  output mem_wb_reg_t       mem_wb_next,
  output logic              mem_stall,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_be,
  output logic [XLEN-1:0]   dbus_wdata,
  input  logic              dbus_ack,
  input  logic [XLEN-1:0]   dbus_rdata
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              mem_exc,
  output logic [31:0]       mem_exc_addr
`endif
);

  mem_state_t        state, state_nx;
  logic [XLEN-1:0]   load_buf;
  logic              drop;
  logic              is_mem;
  logic              trap;
  logic              latch;
  logic              exc;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_load;
  mem_wb_reg_t       wb_word;
  logic [31:0]       unused_pc;

  assign unused_pc = ex_mem_reg.pc_plus_4;
  assign is_mem    = ex_mem_reg.valid & (ex_mem_reg.mem_read | ex_mem_reg.mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = ((ex_mem_reg.mem_width == MEM_H) & ex_mem_reg.alu_result[0]) |
                (ex_mem_reg.mem_width[1] & (|ex_mem_reg.alu_result[1:0]));
  assign mem_exc      = exc;
  assign mem_exc_addr = ex_mem_reg.alu_result;
`else
  assign trap = 1'b0;
`endif

  mem_align u_align (
    .width         (ex_mem_reg.mem_width),
    .addr_lo       (ex_mem_reg.alu_result[1:0]),
    .store_data    (ex_mem_reg.rs2_data),
    .load_data     (dbus_rdata),
    .load_unsigned (ex_mem_reg.mem_unsigned),
    .be            (al_be),
    .wdata         (al_wdata),
    .load_ext      (al_load)
  );

  always_comb begin
    wb_word           = '0;
    wb_word.wb_data   = ex_mem_reg.mem_to_reg ? load_buf : ex_mem_reg.alu_result;
    wb_word.rd        = ex_mem_reg.rd;
    wb_word.reg_write = ex_mem_reg.reg_write;
    wb_word.valid     = 1'b1;
  end

  always_comb begin
    state_nx    = state;
    mem_stall   = 1'b0;
    mem_wb_next = '0;
    latch       = 1'b0;
    exc         = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem & ~flush) begin
          if (trap) begin
            exc = 1'b1;
          end else begin
            mem_stall = 1'b1;
            latch     = 1'b1;
            state_nx  = BUSY;
          end
        end else if (ex_mem_reg.valid & ~flush) begin
          mem_wb_next = wb_word;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (dbus_ack) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
        if (ex_mem_reg.valid & ~flush & ~drop) mem_wb_next = wb_word;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A flush seen while BUSY cannot abort the bus cycle, so it is remembered
  // until DONE and only suppresses the writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
      load_buf   <= '0;
      drop       <= 1'b0;
    end else begin
      state <= state_nx;
      if (latch) begin
        dbus_req   <= 1'b1;
        dbus_we    <= ex_mem_reg.mem_write;
        dbus_addr  <= {ex_mem_reg.alu_result[ADDR_W-1:2], 2'b00};
        dbus_be    <= al_be;
        dbus_wdata <= al_wdata;
      end
      if (state == BUSY) begin
        if (flush) drop <= 1'b1;
        if (dbus_ack) begin
          dbus_req <= 1'b0;
          load_buf <= al_load;
        end
      end
      if (state == DONE) drop <= 1'b0;
    end
  end

endmodule
